prog_counter: RTL and testbench
===============================

Name: prog_counter

Overview:
- Parametrised, programmable counter and next generation of the basic free-running counter.
- Adds width, up/down direction, enable, parallel load, programmable limit, wrap or saturate mode, a step prescaler, and registered tick/terminal flags.
- Used as the generic timebase and event counter across designs; drives LEDs, timeouts and rate dividers.

Parameters:
- WIDTH, 8, count register width in bits.
- PRESCALE_W, 4, prescaler counter width in bits.

Ports:
- i_Clock  in  1  single clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Enable  in  1  counting enable; prescaler and count hold when low.
- i_Up  in  1  direction: 1 counts up, 0 counts down.
- i_Saturate  in  1  mode: 0 wraps, 1 saturates at boundary.
- i_Limit  in  WIDTH  upper bound, inclusive; the count range is 0..i_Limit.
- i_Prescale  in  PRESCALE_W  one count step per i_Prescale+1 enabled cycles.
- i_Load  in  1  parallel load strobe.
- i_LoadValue  in  WIDTH  value to load.
- o_Count  out  WIDTH  current count, registered.
- o_Tick  out  1  one-cycle pulse coincident with every count step.
- o_Terminal  out  1  one-cycle pulse on a step taken at the boundary.
- o_AtLimit  out  1  level: o_Count == i_Limit (up) or o_Count == 0 (down), combinational from o_Count and inputs.

Behaviour:
- Clock/reset: one clock, i_Clock. Reset is synchronous and active-high on i_Reset.
- Reset: o_Count=0, prescaler=0, o_Tick=0, o_Terminal=0.
- Priority: i_Reset > i_Load > step. All inputs are sampled at the edge. The effect is visible the cycle after the sampling edge.
- Load:
  - o_Count <= min(i_LoadValue, i_Limit).
  - Prescaler cleared to 0.
  - o_Tick=0 and o_Terminal=0 that cycle.
  - A load with i_Enable high takes no step.
- Prescaler:
  - When i_Enable=1 and prescaler >= i_Prescale: a step occurs and the prescaler returns to 0.
  - Otherwise, with i_Enable=1, the prescaler increments.
  - With i_Enable=0, the prescaler holds.
  - Using >= makes a live reduction of i_Prescale take effect on the next enabled cycle.
- Step, up:
  - If count < i_Limit: count+1.
  - If count >= i_Limit: wrap gives 0, saturate gives i_Limit. o_Terminal=1 in both modes.
- Step, down:
  - If count > i_Limit: count = i_Limit, with no terminal pulse.
  - Else if count > 0: count-1.
  - If count == 0: wrap gives i_Limit, saturate gives 0. o_Terminal=1 in both modes.
- Flags:
  - o_Tick and o_Terminal are registered with o_Count. They are high exactly in the cycle o_Count shows the post-step value.
  - In saturate mode, o_Terminal repeats on every step attempted at the boundary.
- Arithmetic: all arithmetic is modulo 2^WIDTH internally. i_Limit = 2^WIDTH-1 gives a full-range natural wrap.
- i_Limit = 0: the count stays 0 and every step pulses o_Terminal.
- Direction, mode and limit changes: may occur on any cycle and apply to the next step with no pipeline flush.
- Latency: one cycle from the qualifying edge to o_Count, o_Tick and o_Terminal.

Decomposition:
- Package prog_counter_pkg holds:
  - Constants DIR_DOWN=0, DIR_UP=1, MODE_WRAP=0, MODE_SAT=1.
  - Default widths.
- Sub-module step_prescaler (PRESCALE_W):
  - Inputs: i_Clock, i_Reset, i_Enable, i_Clear (driven by load), i_Prescale.
  - Output: o_Step, combinational.
- The top level holds the count register, boundary logic and flags.

Test Plan:
1. Reset, then enable, up, wrap, prescale 0, limit 9 -> o_Count 0,1..9,0 on consecutive cycles; o_Tick high every cycle; o_Terminal high only in the cycle o_Count returns to 0; o_AtLimit high while o_Count=9.
2. Prescale 2, up, limit 255 -> o_Count steps every 3rd enabled cycle. Drop i_Enable for 5 cycles mid-phase -> count and prescaler phase hold; stepping resumes with the same phase. Full-range check: 255 -> 0 with o_Terminal.
3. Load 3, down, saturate, prescale 0 -> o_Count 3,2,1,0,0,0; o_Terminal on the 4th and 5th steps at 0 (output cycles 5 and 6); o_Tick on all steps.
4. Limit 100, enabled, assert i_Load with value 200 -> o_Count=100 next cycle; o_Tick=0; prescaler cleared. Next up step in wrap mode -> 0 with o_Terminal.
5. Count at 50, limit changed to 20. Up, wrap -> next step 0 with o_Terminal. Repeat with down -> 20 with no o_Terminal. Repeat with saturate, up -> 20 with o_Terminal.
6. i_Reset and i_Load asserted together mid-count at 7 with prescaler mid-phase -> next cycle o_Count=0, prescaler=0, o_Tick=0, o_Terminal=0. Counting resumes from 0 after reset drops.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared constants for the programmable counter: direction and mode encodings
// plus default widths used by the top level and the step prescaler.
package prog_counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_PRESCALE_W = 4;

endpackage

// File: rtl/prog_counter_step_prescaler.sv
// Step prescaler: asserts o_Step once every i_Prescale+1 enabled cycles.
// The phase holds while disabled and is cleared by reset or a parallel load.
module step_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic                  i_Clear,
  input  logic [PRESCALE_W-1:0] i_Prescale,
  output logic                  o_Step
);

  logic [PRESCALE_W-1:0] phase_q;

  // >= rather than == so that lowering i_Prescale below the current phase
  // fires on the very next enabled cycle instead of running the phase around.
  assign o_Step = i_Enable && (phase_q >= i_Prescale);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Clear) begin
      phase_q <= '0;
    end else if (i_Enable) begin
      phase_q <= o_Step ? '0 : phase_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with inclusive limit, wrap/saturate modes,
// parallel load, step prescaler and registered tick/terminal pulses.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic                  i_Up,
  input  logic                  i_Saturate,
  input  logic [WIDTH-1:0]      i_Limit,
  input  logic [PRESCALE_W-1:0] i_Prescale,
  input  logic                  i_Load,
  input  logic [WIDTH-1:0]      i_LoadValue,
  output logic [WIDTH-1:0]      o_Count,
  output logic                  o_Tick,
  output logic                  o_Terminal,
  output logic                  o_AtLimit
);

  logic             step_raw;
  logic             step;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             terminal_d;
  logic             tick_q;
  logic             terminal_q;

  step_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_step_prescaler (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Enable   (i_Enable),
    .i_Clear    (i_Load),
    .i_Prescale (i_Prescale),
    .o_Step     (step_raw)
  );

  // A load overrides any step that the prescaler would grant this cycle.
  assign step = step_raw && !i_Load;

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    count_d    = count_q;
    terminal_d = 1'b0;
    if (i_Up == DIR_UP) begin
      if (count_q >= i_Limit) begin
        count_d    = (i_Saturate == MODE_SAT) ? i_Limit : '0;
        terminal_d = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else begin
      if (count_q > i_Limit) begin
        // Limit lowered below the count: snap down without a terminal pulse.
        count_d = i_Limit;
      end else if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        count_d    = (i_Saturate == MODE_SAT) ? '0 : i_Limit;
        terminal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      count_q    <= '0;
      tick_q     <= 1'b0;
      terminal_q <= 1'b0;
    end else if (i_Load) begin
      count_q    <= (i_LoadValue > i_Limit) ? i_Limit : i_LoadValue;
      tick_q     <= 1'b0;
      terminal_q <= 1'b0;
    end else begin
      tick_q     <= step;
      terminal_q <= step && terminal_d;
      if (step) begin
        count_q <= count_d;
      end
    end
  end

  assign o_Count    = count_q;
  assign o_Tick     = tick_q;
  assign o_Terminal = terminal_q;
  assign o_AtLimit  = (i_Up == DIR_UP) ? (count_q == i_Limit) : (count_q == '0);

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed scenarios against expected
// sequences, then randomized stimulus against an integer reference model.
module tb_prog_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          i_Clock = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Enable = 1'b0;
  logic          i_Up = 1'b1;
  logic          i_Saturate = 1'b0;
  logic [W-1:0]  i_Limit = '0;
  logic [PW-1:0] i_Prescale = '0;
  logic          i_Load = 1'b0;
  logic [W-1:0]  i_LoadValue = '0;
  logic [W-1:0]  o_Count;
  logic          o_Tick;
  logic          o_Terminal;
  logic          o_AtLimit;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, in plain integers.
  int m_count = 0;
  int m_pre   = 0;
  int m_tick  = 0;
  int m_term  = 0;

  prog_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Enable    (i_Enable),
    .i_Up        (i_Up),
    .i_Saturate  (i_Saturate),
    .i_Limit     (i_Limit),
    .i_Prescale  (i_Prescale),
    .i_Load      (i_Load),
    .i_LoadValue (i_LoadValue),
    .o_Count     (o_Count),
    .o_Tick      (o_Tick),
    .o_Terminal  (o_Terminal),
    .o_AtLimit   (o_AtLimit)
  );

  always #5 i_Clock = ~i_Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_update();
    int lim;
    lim = int'(i_Limit);
    if (i_Reset) begin
      m_count = 0; m_pre = 0; m_tick = 0; m_term = 0;
    end else if (i_Load) begin
      m_count = (int'(i_LoadValue) > lim) ? lim : int'(i_LoadValue);
      m_pre = 0; m_tick = 0; m_term = 0;
    end else begin
      m_tick = 0; m_term = 0;
      if (i_Enable) begin
        if (m_pre >= int'(i_Prescale)) begin
          m_pre  = 0;
          m_tick = 1;
          if (i_Up) begin
            if (m_count >= lim) begin
              m_term  = 1;
              m_count = i_Saturate ? lim : 0;
            end else m_count = m_count + 1;
          end else begin
            if (m_count > lim) m_count = lim;
            else if (m_count > 0) m_count = m_count - 1;
            else begin
              m_term  = 1;
              m_count = i_Saturate ? 0 : lim;
            end
          end
        end else m_pre = m_pre + 1;
      end
    end
  endtask

  // Advance one clock, step the model on the same edge, then settle.
  task automatic cycle();
    @(posedge i_Clock);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic en, input logic up, input logic sat,
                        input int lim, input int presc,
                        input logic ld, input int lv);
    i_Enable = en; i_Up = up; i_Saturate = sat;
    i_Limit = W'(lim); i_Prescale = PW'(presc);
    i_Load = ld; i_LoadValue = W'(lv);
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 9, 0, 1'b0, 0);
    cycle(); cycle();
    n_tests++;
    if (o_Count !== W'(0) || o_Tick !== 1'b0 || o_Terminal !== 1'b0 || o_AtLimit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: count=%0d tick=%b term=%b atlim=%b, need 0/0/0/0",
               o_Count, o_Tick, o_Terminal, o_AtLimit);
    end
  endtask

  task automatic test_wrap_up();
    int exp;
    i_Reset = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 9, 0, 1'b0, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      exp = k % 10;
      n_tests++;
      if (o_Count !== W'(exp) || o_Tick !== 1'b1 || o_Terminal !== (k == 10)
          || o_AtLimit !== (exp == 9)) begin
        n_fail++;
        $display("FAIL wrap_up k=%0d: count=%0d tick=%b term=%b atlim=%b, need %0d/1/%b/%b",
                 k, o_Count, o_Tick, o_Terminal, o_AtLimit, exp, k == 10, exp == 9);
      end
    end
  endtask

  task automatic test_prescale_hold();
    i_Reset = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 255, 2, 1'b0, 0);
    cycle();
    i_Reset = 1'b0;
    i_Enable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      n_tests++;
      if (o_Count !== W'(k / 3) || o_Tick !== (k % 3 == 0)) begin
        n_fail++;
        $display("FAIL prescale k=%0d: count=%0d tick=%b, need %0d/%b",
                 k, o_Count, o_Tick, k / 3, k % 3 == 0);
      end
    end
    i_Enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_tests++;
      if (o_Count !== W'(2) || o_Tick !== 1'b0) begin
        n_fail++;
        $display("FAIL hold k=%0d: count=%0d tick=%b, need 2/0", k, o_Count, o_Tick);
      end
    end
    i_Enable = 1'b1;
    cycle();
    n_tests++;
    if (o_Count !== W'(2) || o_Tick !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_phase: count=%0d tick=%b, need 2/0", o_Count, o_Tick);
    end
    cycle();
    n_tests++;
    if (o_Count !== W'(3) || o_Tick !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_step: count=%0d tick=%b, need 3/1", o_Count, o_Tick);
    end
    set_in(1'b1, 1'b1, 1'b0, 255, 0, 1'b1, 255);
    cycle();
    n_tests++;
    if (o_Count !== W'(255) || o_Tick !== 1'b0 || o_AtLimit !== 1'b1) begin
      n_fail++;
      $display("FAIL load_255: count=%0d tick=%b atlim=%b, need 255/0/1", o_Count, o_Tick, o_AtLimit);
    end
    i_Load = 1'b0;
    cycle();
    n_tests++;
    if (o_Count !== W'(0) || o_Tick !== 1'b1 || o_Terminal !== 1'b1) begin
      n_fail++;
      $display("FAIL full_range: count=%0d tick=%b term=%b, need 0/1/1", o_Count, o_Tick, o_Terminal);
    end
  endtask

  task automatic test_down_saturate();
    int exp;
    set_in(1'b1, 1'b0, 1'b1, 255, 0, 1'b1, 3);
    cycle();
    n_tests++;
    if (o_Count !== W'(3) || o_Tick !== 1'b0) begin
      n_fail++;
      $display("FAIL down_load: count=%0d tick=%b, need 3/0", o_Count, o_Tick);
    end
    i_Load = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      cycle();
      exp = (3 - s > 0) ? 3 - s : 0;
      n_tests++;
      if (o_Count !== W'(exp) || o_Tick !== 1'b1 || o_Terminal !== (s >= 4)) begin
        n_fail++;
        $display("FAIL down_sat s=%0d: count=%0d tick=%b term=%b, need %0d/1/%b",
                 s, o_Count, o_Tick, o_Terminal, exp, s >= 4);
      end
    end
  endtask

  task automatic test_load_clamp();
    // Run the prescaler to mid-phase first so the load's clear is observable.
    set_in(1'b1, 1'b1, 1'b0, 100, 3, 1'b0, 0);
    cycle(); cycle();
    i_Load = 1'b1; i_LoadValue = W'(200);
    cycle();
    n_tests++;
    if (o_Count !== W'(100) || o_Tick !== 1'b0 || o_Terminal !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clamp: count=%0d tick=%b term=%b, need 100/0/0", o_Count, o_Tick, o_Terminal);
    end
    i_Load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      n_tests++;
      if (o_Count !== W'((k == 4) ? 0 : 100) || o_Tick !== (k == 4) || o_Terminal !== (k == 4)) begin
        n_fail++;
        $display("FAIL load_wrap k=%0d: count=%0d tick=%b term=%b, need %0d/%b/%b",
                 k, o_Count, o_Tick, o_Terminal, (k == 4) ? 0 : 100, k == 4, k == 4);
      end
    end
  endtask

  task automatic test_limit_change();
    logic up_v  [3] = '{1'b1, 1'b0, 1'b1};
    logic sat_v [3] = '{1'b0, 1'b0, 1'b1};
    int   exp_c [3] = '{0, 20, 20};
    logic exp_t [3] = '{1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 3; c++) begin
      set_in(1'b0, 1'b1, 1'b0, 255, 0, 1'b1, 50);
      cycle();
      set_in(1'b1, up_v[c], sat_v[c], 20, 0, 1'b0, 0);
      cycle();
      n_tests++;
      if (o_Count !== W'(exp_c[c]) || o_Tick !== 1'b1 || o_Terminal !== exp_t[c]) begin
        n_fail++;
        $display("FAIL limit_change c=%0d: count=%0d tick=%b term=%b, need %0d/1/%b",
                 c, o_Count, o_Tick, o_Terminal, exp_c[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_reset_over_load();
    set_in(1'b1, 1'b1, 1'b0, 255, 3, 1'b1, 7);
    cycle();
    i_Load = 1'b0;
    cycle(); cycle();
    i_Reset = 1'b1; i_Load = 1'b1; i_LoadValue = W'(99);
    cycle();
    n_tests++;
    if (o_Count !== W'(0) || o_Tick !== 1'b0 || o_Terminal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_load: count=%0d tick=%b term=%b, need 0/0/0", o_Count, o_Tick, o_Terminal);
    end
    i_Reset = 1'b0; i_Load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      n_tests++;
      if (o_Count !== W'((k == 4) ? 1 : 0) || o_Tick !== (k == 4)) begin
        n_fail++;
        $display("FAIL post_reset k=%0d: count=%0d tick=%b, need %0d/%b",
                 k, o_Count, o_Tick, (k == 4) ? 1 : 0, k == 4);
      end
    end
  endtask

  task automatic test_random();
    int r;
    int lim;
    logic exp_at;
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      lim = (r < 3) ? 255 : (r == 3) ? 0 : int'($urandom_range(0, 255));
      i_Reset     = ($urandom_range(0, 49) == 0);
      i_Enable    = ($urandom_range(0, 4) != 0);
      i_Up        = $urandom_range(0, 1) != 0;
      i_Saturate  = $urandom_range(0, 1) != 0;
      i_Limit     = W'(lim);
      i_Prescale  = PW'($urandom_range(0, 3));
      i_Load      = ($urandom_range(0, 9) == 0);
      i_LoadValue = W'($urandom_range(0, 255));
      cycle();
      exp_at = i_Up ? (m_count == int'(i_Limit)) : (m_count == 0);
      n_tests++;
      if (o_Count !== W'(m_count) || o_Tick !== (m_tick != 0) || o_Terminal !== (m_term != 0)
          || o_AtLimit !== exp_at) begin
        n_fail++;
        $display("FAIL random n=%0d: count=%0d tick=%b term=%b atlim=%b, need %0d/%0d/%0d/%b",
                 n, o_Count, o_Tick, o_Terminal, o_AtLimit, m_count, m_tick, m_term, exp_at);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_prescale_hold();
    test_down_saturate();
    test_load_clamp();
    test_limit_change();
    test_reset_over_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
